pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequencing controller for the 5-stage pipeline around the execute stage.
//  Generates IF/ID/EX stall and flush, registered operand-forward selects for EX, and the
//  start/wait handshake for multi-cycle EX ops (M-ext divide).
//  Sits beside ID/EX; consumes ID source regs, EX/MEM dest info and the EX redirect (pc_select).
// PARAMETERS
//  REG_AW      5   register address width
//  CNT_W       16  width of saturating stall-cycle counter
//  MC_TIMEOUT  64  max MC_WAIT cycles before err_o; 0 disables watchdog
// PORTS
//  clk_i            in   1       clock
//  reset_i          in   1       synchronous, active-low reset
//  id_rs1_i         in   REG_AW  ID source reg 1
//  id_rs2_i         in   REG_AW  ID source reg 2
//  id_use_rs1_i     in   1       ID instr reads rs1
//  id_use_rs2_i     in   1       ID instr reads rs2
//  ex_rd_i          in   REG_AW  EX dest reg
//  ex_regwrite_i    in   1       EX instr writes rd
//  ex_memread_i     in   1       EX instr is a load
//  ex_mc_i          in   1       EX instr is multi-cycle
//  mem_rd_i         in   REG_AW  MEM dest reg
//  mem_regwrite_i   in   1       MEM instr writes rd
//  ex_pc_select_i   in   1       EX redirect (branch taken / jump)
//  mc_done_i        in   1       multi-cycle unit result valid (1-cycle pulse)
//  stall_if_o       out  1       hold PC
//  stall_id_o       out  1       hold IF/ID register
//  stall_ex_o       out  1       hold ID/EX register and EX inputs
//  flush_id_o       out  1       IF/ID becomes NOP
//  flush_ex_o       out  1       ID/EX becomes bubble
//  fwd_a_o          out  2       EX op1 source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//  fwd_b_o          out  2       EX op2 source, same encoding
//  mc_start_o       out  1       1-cycle start pulse to multi-cycle unit
//  stall_cycles_o   out  CNT_W   cycles with stall_if_o high, saturating
//  err_o            out  1       sticky MC watchdog expiry
// BEHAVIOUR
//  - Reset (reset_i=0 at posedge): state RUN; all outputs 0; counter and watchdog 0.
//  - hz(r): r!=0 && r matches a used ID source. x0 never stalls/forwards.
//  - States RUN, MC_WAIT. Priority in RUN: redirect > MC entry > load-use > none.
//  - Redirect: ex_pc_select_i=1 -> flush_id_o=flush_ex_o=1 same cycle; no stall;
//    load-use on that cycle suppressed.
//  - Load-use: ex_memread_i && ex_regwrite_i && hz(ex_rd_i) -> stall_if, stall_id,
//    flush_ex = 1 for exactly 1 cycle (next cycle the load is in MEM, hazard clears).
//  - MC entry: RUN && ex_mc_i && !ex_pc_select_i -> mc_start_o=1 that cycle, go MC_WAIT.
//  - MC_WAIT: stall_if/id/ex=1; redirect, load-use ignored.
//    mc_done_i -> stalls drop same cycle, go RUN.
//    Watchdog counts MC_WAIT cycles; reaching MC_TIMEOUT sets err_o, forces RUN.
//  - Forward selects: registered, updated on ID->EX advance (stall_ex_o=0, stall_id_o=0):
//    match ex_rd_i && ex_regwrite_i -> 01; else mem_rd_i && mem_regwrite_i -> 10; else 00.
//    EX/MEM beats MEM/WB. Cleared to 00 when flush_ex_o=1; held while stall_ex_o=1.
//    WB-same-cycle write is covered by regfile write-through, not here.
//  - stall_cycles_o += 1 each cycle stall_if_o=1; saturates at all-ones.
//  - Reset mid-MC_WAIT: immediate RUN, no mc_start_o re-issue, err_o cleared.
// STRUCTURE
//  - pipeline_pkg: FWD_RF/FWD_EXMEM/FWD_MEMWB encodings, ctrl state enum (RUN, MC_WAIT).
//  - Sub-module fwd_select (combinational rs-vs-rd compare), instantiated for rs1 and rs2.
//  - Top: FSM, stall/flush decode, forward regs, watchdog, perf counter.
// TESTING
//  1. add x5 in EX, add reading x5 in ID -> next cycle fwd_a_o=01, no stall.
//  2. lw x7 in EX, ID reads rs2=x7 -> 1 cycle stall_if/id+flush_ex; then fwd_b_o=10.
//  3. lw x0 in EX, ID reads x0 -> no stall; fwd 00.
//  4. ex_pc_select_i=1 with load-use hazard -> flush_id=flush_ex=1, stall_if=0.
//  5. ex_mc_i=1, mc_done_i after 10 cycles -> mc_start_o 1 cycle; stalls 10 cycles;
//     stall_cycles_o +10.
//  6. MC_TIMEOUT=4, no mc_done_i -> err_o=1 after 4 cycles; RUN; reset_i=0 clears err_o.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the execute-stage sequencing controller.
//   FWD_* : operand-source encodings driven on fwd_a_o / fwd_b_o
//   ctrl_state_e : controller FSM states
package pipeline_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // operand from EX/MEM pipeline register
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // operand from MEM/WB pipeline register

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/fwd_select.sv
// Combinational source-vs-destination compare for one ID operand.
//   rs, use_rs            : ID source register and "instruction reads it" flag
//   ex_rd, ex_regwrite    : destination of the instruction currently in EX
//   mem_rd, mem_regwrite  : destination of the instruction currently in MEM
//   ex_hit                : operand depends on the EX instruction
//   sel                   : forward select this operand needs once it reaches EX
module fwd_select
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              use_rs,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  output logic              ex_hit,
  output logic [1:0]        sel
);

  logic live_s;   // operand is read and is not x0 (x0 never forwards or stalls)
  logic mem_hit_s;

  // Match the operand against the EX and MEM destinations; EX/MEM is younger and wins.
  always_comb begin
    live_s    = use_rs && (rs != {REG_AW{1'b0}});
    ex_hit    = live_s && ex_regwrite && (rs == ex_rd);
    mem_hit_s = live_s && mem_regwrite && (rs == mem_rd);
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit_s) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / flush / forward sequencing around the execute stage.
//   Inputs : ID sources (id_rs*_i, id_use_rs*_i), EX dest info (ex_rd_i, ex_regwrite_i,
//            ex_memread_i, ex_mc_i), MEM dest info, EX redirect (ex_pc_select_i),
//            multi-cycle completion pulse (mc_done_i); clk_i, reset_i (sync, active-low).
//   Outputs: stall_if_o/stall_id_o/stall_ex_o, flush_id_o/flush_ex_o (same-cycle decode),
//            fwd_a_o/fwd_b_o (registered selects for EX), mc_start_o (start pulse),
//            stall_cycles_o (saturating stall counter), err_o (sticky watchdog expiry).
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 16,
  parameter int MC_TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memread_i,
  input  logic              ex_mc_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_regwrite_i,
  input  logic              ex_pc_select_i,
  input  logic              mc_done_i,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic              stall_ex_o,
  output logic              flush_id_o,
  output logic              flush_ex_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              mc_start_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic              err_o
);

  localparam int WD_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;

  ctrl_state_e      state_r, state_s;
  logic [WD_W-1:0]  wd_cnt_r;
  logic             wd_hit_s, wd_expire_s;
  logic             err_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [1:0]       fwd_a_r, fwd_b_r;
  logic [1:0]       sel_a_s, sel_b_s;
  logic             ex_hit_a_s, ex_hit_b_s, load_use_s;
  logic             stall_if_s, stall_id_s, stall_ex_s, flush_id_s, flush_ex_s, mc_start_s;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .rs(id_rs1_i), .use_rs(id_use_rs1_i), .ex_rd(ex_rd_i), .ex_regwrite(ex_regwrite_i),
    .mem_rd(mem_rd_i), .mem_regwrite(mem_regwrite_i), .ex_hit(ex_hit_a_s), .sel(sel_a_s)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .rs(id_rs2_i), .use_rs(id_use_rs2_i), .ex_rd(ex_rd_i), .ex_regwrite(ex_regwrite_i),
    .mem_rd(mem_rd_i), .mem_regwrite(mem_regwrite_i), .ex_hit(ex_hit_b_s), .sel(sel_b_s)
  );

  // Load-use: a load in EX whose result an ID operand needs cannot be forwarded in time.
  assign load_use_s = ex_memread_i && (ex_hit_a_s || ex_hit_b_s);

  // The watchdog fires on the MC_TIMEOUT-th MC_WAIT cycle; a zero timeout disables it.
  assign wd_hit_s = (MC_TIMEOUT != 0) && (wd_cnt_r == WD_W'(MC_TIMEOUT - 1));

  // Next-state and stall/flush/start decode; everything is held at 0 while reset is asserted.
  always_comb begin
    state_s     = state_r;
    stall_if_s  = 1'b0;
    stall_id_s  = 1'b0;
    stall_ex_s  = 1'b0;
    flush_id_s  = 1'b0;
    flush_ex_s  = 1'b0;
    mc_start_s  = 1'b0;
    wd_expire_s = 1'b0;
    if (!reset_i) begin
      state_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (ex_pc_select_i) begin
            flush_id_s = 1'b1;
            flush_ex_s = 1'b1;
          end else if (ex_mc_i) begin
            mc_start_s = 1'b1;
            state_s    = ST_MC_WAIT;
          end else if (load_use_s) begin
            stall_if_s = 1'b1;
            stall_id_s = 1'b1;
            flush_ex_s = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_MC_WAIT: begin
          if (mc_done_i) begin
            state_s = ST_RUN;
          end else if (wd_hit_s) begin
            stall_if_s  = 1'b1;
            stall_id_s  = 1'b1;
            stall_ex_s  = 1'b1;
            wd_expire_s = 1'b1;
            state_s     = ST_RUN;
          end else begin
            stall_if_s = 1'b1;
            stall_id_s = 1'b1;
            stall_ex_s = 1'b1;
          end
        end
        default: begin
          state_s = ST_RUN;
        end
      endcase
    end
  end

  // State, watchdog, sticky error, stall counter and forward-select registers.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r     <= ST_RUN;
      wd_cnt_r    <= {WD_W{1'b0}};
      err_r       <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
      fwd_a_r     <= FWD_RF;
      fwd_b_r     <= FWD_RF;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_MC_WAIT) && (state_s == ST_MC_WAIT)) begin
        wd_cnt_r <= wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
      end else begin
        wd_cnt_r <= {WD_W{1'b0}};
      end
      if (wd_expire_s) begin
        err_r <= 1'b1;
      end
      if (stall_if_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      // A bubble entering EX forwards nothing; selects only move when ID advances into EX.
      if (flush_ex_s) begin
        fwd_a_r <= FWD_RF;
        fwd_b_r <= FWD_RF;
      end else if (!stall_ex_s && !stall_id_s) begin
        fwd_a_r <= sel_a_s;
        fwd_b_r <= sel_b_s;
      end
    end
  end

  assign stall_if_o     = stall_if_s;
  assign stall_id_o     = stall_id_s;
  assign stall_ex_o     = stall_ex_s;
  assign flush_id_o     = flush_id_s;
  assign flush_ex_o     = flush_ex_s;
  assign mc_start_o     = mc_start_s;
  assign fwd_a_o        = fwd_a_r;
  assign fwd_b_o        = fwd_b_r;
  assign stall_cycles_o = stall_cnt_r;
  assign err_o          = err_r;

endmodule
